mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage access controller sitting directly downstream of the EX/MEM pipeline register. It consumes the MEM-stage control and data (read/write strobes, ALU-computed address, store data, access size) and runs a request/acknowledge transaction on the data-memory bus. It performs byte-lane steering for stores and lane extraction with sign/zero extension for loads, and holds the pipeline with a stall while an access is outstanding.

## Interface
- No parameters; data and address widths fixed at 32 bits.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_read_m  in  1  load in MEM stage.
- mem_write_m  in  1  store in MEM stage.
- addr_m  in  32  byte address (ALU result).
- wdata_m  in  32  store data, right-justified.
- size_m  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- load_unsigned_m  in  1  1 = zero-extend load, 0 = sign-extend.
- bus_req  out  1  transaction request, held until ack.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address, bits [1:0] always 0.
- bus_be  out  4  byte enables, little-endian.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  transaction complete; rdata valid same cycle for reads.
- bus_rdata  in  32  read word.
- stall_m  out  1  freeze IF/ID/EX/MEM registers.
- rdata_m  out  32  extended load result, registered.
- misalign_m  out  1  misaligned-access flag (see Configuration).

## Operation
- FSM states IDLE, BUSY, DONE.
- IDLE: access = mem_read_m | mem_write_m. If access, register bus_we (= mem_write_m; write wins if both set), bus_addr, bus_be, bus_wdata, size, extension mode, addr[1:0]; go BUSY.
- BUSY: bus_req = 1, all bus outputs stable. On bus_ack: if read, capture extended lane into rdata_m; go DONE. No timeout.
- DONE: one cycle, no bus activity, stall_m = 0 so the pipeline advances; go IDLE unconditionally (the same instruction is still presented this cycle and must not start a second access).
- stall_m = (IDLE & access) | BUSY; combinational from state and inputs.
- Byte enables: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111.
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load: byte lane bus_rdata[8*a+7:8*a], half lane at addr[1]; extended to 32 bits per load_unsigned_m. Word passes through.
- rdata_m holds its last value until the next read completes; stores do not change it.
- Reset values: state IDLE, bus_req 0, bus_we 0, bus_addr 0, bus_be 0, bus_wdata 0, rdata_m 0, misalign_m 0; stall_m 0 given no access.
- Reset mid-transaction: returns to IDLE immediately, bus_req drops asynchronously; any late ack ignored.

## Timing
- Minimum access: 3 cycles (IDLE detect, BUSY with ack on first BUSY cycle, DONE). Each extra ack wait cycle adds one.
- bus_req rises the cycle after the access is detected; falls the cycle after ack.
- rdata_m valid in DONE and thereafter.
- Back-to-back accesses: at least one IDLE cycle between DONE and the next BUSY.

## Configuration
- MEM_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=00 is misaligned; IDLE goes directly to DONE, no bus transaction, misalign_m = 1 for the DONE cycle only, rdata_m unchanged.
- Undefined: no check; half ignores addr[0], word ignores addr[1:0]; misalign_m tied 0.

## Structure
- Package mem_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, byte-enable generation function.
- Sub-module mem_lane_align: combinational store replication and load extraction/extension; controller holds FSM and registers.

## Test plan
- Word store addr 0x100, wdata 0xDEADBEEF, ack on first BUSY cycle -> bus_addr 0x100, be 1111, bus_we 1, stall_m high 2 cycles, low in DONE.
- Byte load addr 0x203, rdata 0x80xxxxxx, signed -> be 1000, rdata_m 0xFFFFFF80; unsigned -> 0x00000080.
- Half store addr 0x22, wdata 0x1234ABCD, ack delayed 4 cycles -> bus_wdata 0xABCDABCD, be 1100, bus_req held 5 cycles, stall_m 6 cycles.
- Word load addr 0x101 with MEM_ALIGN_CHECK_EN -> bus_req never rises, misalign_m one-cycle pulse, rdata_m unchanged; without macro -> bus_addr 0x100 normal load.
- rst_n low during BUSY -> bus_req 0 immediately, state IDLE, stall_m 0 with no access presented.
- Two consecutive loads -> DONE then IDLE then BUSY; second ack data lands in rdata_m only after second DONE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access controller: size codes, FSM
// state type and byte-enable / alignment helpers.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Size code 11 behaves as a word everywhere.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << addr_lo;
      SZ_HALF: byte_en = 4'b0011 << {addr_lo[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr_lo[0];
      default: misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data replication across lanes and load lane
// extraction with sign/zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [31:0] st_wdata,
  output logic [31:0] st_data,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] byte_sh;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    case (st_size)
      SZ_BYTE: st_data = {4{st_wdata[7:0]}};
      SZ_HALF: st_data = {2{st_wdata[15:0]}};
      default: st_data = st_wdata;
    endcase
  end

  always_comb begin
    byte_sh = ld_rdata >> {ld_addr_lo, 3'b000};
    ld_byte = byte_sh[7:0];
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_size)
      SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller (req/ack bus, stall generation).
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  input  logic [1:0]  size_m,
  input  logic        load_unsigned_m,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall_m,
  output logic [31:0] rdata_m,
  output logic        misalign_m
);

  state_e      state;
  logic [1:0]  size_q;
  logic [1:0]  addr_lo_q;
  logic        unsigned_q;
  logic        access;
  logic        bad_align;
  logic [31:0] store_data;
  logic [31:0] load_data;

  assign access = mem_read_m | mem_write_m;

`ifdef MEM_ALIGN_CHECK_EN
  assign bad_align = misaligned(size_m, addr_m[1:0]);
`else
  assign bad_align = 1'b0;
`endif

  // Decoding straight off state makes bus_req fall with the async reset.
  assign bus_req = (state == ST_BUSY);
  assign stall_m = ((state == ST_IDLE) && access) || (state == ST_BUSY);

  mem_lane_align u_lane_align (
    .st_size     (size_m),
    .st_wdata    (wdata_m),
    .st_data     (store_data),
    .ld_size     (size_q),
    .ld_addr_lo  (addr_lo_q),
    .ld_unsigned (unsigned_q),
    .ld_rdata    (bus_rdata),
    .ld_data     (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      size_q     <= '0;
      addr_lo_q  <= '0;
      unsigned_q <= 1'b0;
      rdata_m    <= '0;
      misalign_m <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access) begin
            if (bad_align) begin
              misalign_m <= 1'b1;
              state      <= ST_DONE;
            end else begin
              bus_we     <= mem_write_m;
              bus_addr   <= {addr_m[31:2], 2'b00};
              bus_be     <= byte_en(size_m, addr_m[1:0]);
              bus_wdata  <= store_data;
              size_q     <= size_m;
              addr_lo_q  <= addr_m[1:0];
              unsigned_q <= load_unsigned_m;
              state      <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (bus_ack) begin
            if (!bus_we) rdata_m <= load_data;
            state <= ST_DONE;
          end
        end
        // The instruction is still presented here; returning to IDLE
        // unconditionally keeps it from launching a second access.
        ST_DONE: begin
          misalign_m <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// accesses against a lane/size reference model.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        mem_read_m;
  logic        mem_write_m;
  logic [31:0] addr_m;
  logic [31:0] wdata_m;
  logic [1:0]  size_m;
  logic        load_unsigned_m;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stall_m;
  logic [31:0] rdata_m;
  logic        misalign_m;

  int unsigned n_cmp;
  int unsigned n_bad;
  logic [31:0] model_rdata;

  mem_access_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read_m      (mem_read_m),
    .mem_write_m     (mem_write_m),
    .addr_m          (addr_m),
    .wdata_m         (wdata_m),
    .size_m          (size_m),
    .load_unsigned_m (load_unsigned_m),
    .bus_req         (bus_req),
    .bus_we          (bus_we),
    .bus_addr        (bus_addr),
    .bus_be          (bus_be),
    .bus_wdata       (bus_wdata),
    .bus_ack         (bus_ack),
    .bus_rdata       (bus_rdata),
    .stall_m         (stall_m),
    .rdata_m         (rdata_m),
    .misalign_m      (misalign_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned size_bytes(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  // A lane is enabled when it falls in the same naturally aligned chunk as the address.
  function automatic logic [31:0] exp_be(input logic [1:0] sz, input logic [1:0] a);
    int unsigned nb;
    int unsigned ai;
    logic [31:0] be;
    nb = size_bytes(sz);
    ai = a;
    be = '0;
    for (int unsigned i = 0; i < 4; i++)
      if ((i / nb) == (ai / nb)) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input logic [1:0] sz);
    if (sz == 2'b00) return {24'd0, wd[7:0]} * 32'h0101_0101;
    if (sz == 2'b01) return {16'd0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] a, input logic uns);
    int unsigned nb;
    int unsigned off;
    int unsigned ai;
    logic [31:0] v;
    logic [31:0] mask;
    nb  = size_bytes(sz);
    ai  = a;
    off = (ai / nb) * nb;
    v   = w >> (8 * off);
    if (nb == 4) return v;
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v = v & mask;
    if (!uns && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic is_mis(input logic [1:0] sz, input logic [1:0] a);
    int unsigned ai;
    ai = a;
    return (ai % size_bytes(sz)) != 0;
  endfunction

  // Starts in an IDLE cycle just after a falling edge; ends the same way.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                            input int unsigned delay, input logic [31:0] rword,
                            input string tag);
    int unsigned nreq;
    int unsigned nstall;
    logic mis;
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = is_mis(sz, addr[1:0]);
`endif
    mem_read_m = rd; mem_write_m = wr; addr_m = addr; wdata_m = wd;
    size_m = sz; load_unsigned_m = uns;
    #1;
    check({tag, ".idle_stall"}, {31'd0, stall_m}, 32'd1);
    check({tag, ".idle_req"}, {31'd0, bus_req}, 32'd0);
    if (mis) begin
      @(negedge clk); #1;
      check({tag, ".mis_req"}, {31'd0, bus_req}, 32'd0);
      check({tag, ".mis_flag"}, {31'd0, misalign_m}, 32'd1);
      check({tag, ".mis_stall"}, {31'd0, stall_m}, 32'd0);
      check({tag, ".mis_rdata"}, rdata_m, model_rdata);
      @(negedge clk);
      mem_read_m = 1'b0; mem_write_m = 1'b0;
      #1;
      check({tag, ".mis_clear"}, {31'd0, misalign_m}, 32'd0);
      check({tag, ".mis_req2"}, {31'd0, bus_req}, 32'd0);
    end else begin
      nreq = 0;
      nstall = 1;
      @(negedge clk); #1;
      check({tag, ".addr"}, bus_addr, {addr[31:2], 2'b00});
      check({tag, ".be"}, {28'd0, bus_be}, exp_be(sz, addr[1:0]));
      check({tag, ".we"}, {31'd0, bus_we}, {31'd0, wr});
      check({tag, ".wdata"}, bus_wdata, exp_wdata(wd, sz));
      check({tag, ".rdata_hold"}, rdata_m, model_rdata);
      for (int unsigned i = 0; i <= delay; i++) begin
        if (i > 0) begin
          @(negedge clk); #1;
        end
        nreq += bus_req;
        nstall += stall_m;
        if (i == delay) begin
          bus_ack = 1'b1;
          bus_rdata = rword;
        end
      end
      @(negedge clk);
      bus_ack = 1'b0;
      bus_rdata = $urandom;
      #1;
      if (!wr) model_rdata = exp_load(rword, sz, addr[1:0], uns);
      check({tag, ".done_req"}, {31'd0, bus_req}, 32'd0);
      check({tag, ".done_stall"}, {31'd0, stall_m}, 32'd0);
      check({tag, ".done_mis"}, {31'd0, misalign_m}, 32'd0);
      check({tag, ".rdata"}, rdata_m, model_rdata);
      check({tag, ".req_cycles"}, nreq, delay + 1);
      check({tag, ".stall_cycles"}, nstall, delay + 2);
      @(negedge clk);
      mem_read_m = 1'b0; mem_write_m = 1'b0;
      #1;
      check({tag, ".after_req"}, {31'd0, bus_req}, 32'd0);
      check({tag, ".after_stall"}, {31'd0, stall_m}, 32'd0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_rdata = '0;
    rst_n = 1'b1;
    mem_read_m = 1'b0; mem_write_m = 1'b0; addr_m = '0; wdata_m = '0;
    size_m = 2'b00; load_unsigned_m = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst.req", {31'd0, bus_req}, 32'd0);
    check("rst.we", {31'd0, bus_we}, 32'd0);
    check("rst.addr", bus_addr, 32'd0);
    check("rst.be", {28'd0, bus_be}, 32'd0);
    check("rst.wdata", bus_wdata, 32'd0);
    check("rst.rdata", rdata_m, 32'd0);
    check("rst.mis", {31'd0, misalign_m}, 32'd0);
    check("rst.stall", {31'd0, stall_m}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_access(1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, SZ_WORD, 1'b0, 0, 32'h0, "sw_word");
    run_access(1'b1, 1'b0, 32'h0000_0203, 32'h0, SZ_BYTE, 1'b0, 0, 32'h8012_3456, "lb_signed");
    check("lb_signed.value", rdata_m, 32'hFFFF_FF80);
    run_access(1'b1, 1'b0, 32'h0000_0203, 32'h0, SZ_BYTE, 1'b1, 0, 32'h8012_3456, "lbu");
    check("lbu.value", rdata_m, 32'h0000_0080);
    run_access(1'b0, 1'b1, 32'h0000_0022, 32'h1234_ABCD, SZ_HALF, 1'b0, 4, 32'h0, "sh_delay");
    check("sh_delay.keep_rdata", rdata_m, 32'h0000_0080);
    run_access(1'b1, 1'b0, 32'h0000_0101, 32'h0, SZ_WORD, 1'b0, 1, 32'hCAFE_F00D, "lw_mis");
    run_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, SZ_HALF, 1'b0, 1, 32'h1111_9ABC, "b2b_first");
    run_access(1'b1, 1'b0, 32'h0000_0046, 32'h0, SZ_HALF, 1'b1, 2, 32'hF00D_2222, "b2b_second");
    check("b2b.value", rdata_m, 32'h0000_F00D);

    for (int unsigned n = 0; n < 40; n++) begin
      logic [1:0] kind;
      kind = 2'($urandom_range(1, 3));
      run_access(kind[0], kind[1], $urandom, $urandom, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom, "rand");
    end

    mem_read_m = 1'b1; mem_write_m = 1'b0; addr_m = 32'h0000_0080; size_m = SZ_WORD;
    @(negedge clk); #1;
    check("rstmid.busy_req", {31'd0, bus_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.req_drop", {31'd0, bus_req}, 32'd0);
    mem_read_m = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'h5555_AAAA;
    #1;
    check("rstmid.stall", {31'd0, stall_m}, 32'd0);
    check("rstmid.addr", bus_addr, 32'd0);
    model_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("rstmid.late_ack_req", {31'd0, bus_req}, 32'd0);
    check("rstmid.late_ack_rdata", rdata_m, model_rdata);
    bus_ack = 1'b0;
    @(negedge clk);
    run_access(1'b1, 1'b0, 32'h0000_0300, 32'h0, SZ_BYTE, 1'b1, 0, 32'h0000_007F, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
